// File: rtl/project3_pkg.sv
// rtl/project3_pkg.sv - shared widths and encodings for the main-memory responder
package project3_pkg;

    localparam int adrWIDTH  = 16;
    localparam int dataWIDTH = 8;
    localparam int BURST_LEN = 4;
    localparam int BEAT_W    = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RD_DATA = 2'd3
    } state_t;

    // What BUSY hands off to when its latency count expires
    typedef enum logic {
        RET_NONE = 1'b0,
        RET_RD   = 1'b1
    } ret_t;

endpackage

// File: rtl/mem_byte_array.sv
// rtl/mem_byte_array.sv - byte store, synchronous write, combinational read
module mem_byte_array #(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    WIDTH      = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    initial begin
        for (int i = 0; i < (1 << DEPTH_LOG2); i++) begin
            mem[i] = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - line-burst main-memory responder for the cache controller
module main_mem_responder #(
    parameter int    adrWIDTH       = project3_pkg::adrWIDTH,
    parameter int    dataWIDTH      = project3_pkg::dataWIDTH,
    parameter int    MEM_DEPTH_LOG2 = 10,
    parameter int    LATENCY        = 4,
    parameter string INIT_FILE      = ""
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 readMem,
    input  logic                 writeMem,
    input  logic [adrWIDTH-1:0]  adrMM,
    inout  wire  [dataWIDTH-1:0] dataMM,
    output logic                 readyMem,
    output logic                 dataValidMem,
    output logic                 protocolErr
);

    import project3_pkg::*;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t                    state_q, state_d;
    ret_t                      ret_q, ret_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [MEM_DEPTH_LOG2-1:0] base_q, base_d;
    logic                      ready_q, ready_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;
    logic [dataWIDTH-1:0]      dout_q, dout_d;

    logic                      mem_we;
    logic [MEM_DEPTH_LOG2-1:0] mem_addr;
    logic [dataWIDTH-1:0]      mem_rd_data;

    // Line offset and address bits above the store depth alias away
    logic unused_adr_bits;
    assign unused_adr_bits = ^{adrMM[adrWIDTH-1:MEM_DEPTH_LOG2], adrMM[1:0]};

    assign mem_addr = base_q + MEM_DEPTH_LOG2'(beat_q);

    mem_byte_array #(
        .DEPTH_LOG2 (MEM_DEPTH_LOG2),
        .WIDTH      (dataWIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_mem (
        .CLK     (CLK),
        .we      (mem_we),
        .addr    (mem_addr),
        .wr_data (dataMM),
        .rd_data (mem_rd_data)
    );

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        ready_d = ready_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        dout_d  = dout_q;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                valid_d = 1'b0;
                if (readMem && writeMem) begin
                    err_d = 1'b1;
                end else if (readMem || writeMem) begin
                    base_d  = {adrMM[MEM_DEPTH_LOG2-1:2], 2'b00};
                    beat_d  = '0;
                    ready_d = 1'b0;
                    if (readMem) begin
                        state_d = ST_BUSY;
                        ret_d   = RET_RD;
                        cnt_d   = LAT4;
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end
            end

            ST_WR_DATA: begin
                err_d  = readMem | writeMem;
                mem_we = 1'b1;
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                    state_d = ST_BUSY;
                    ret_d   = RET_NONE;
                    cnt_d   = LAT4;
                end
            end

            ST_BUSY: begin
                err_d = readMem | writeMem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 4'd1) begin
                    ready_d = 1'b1;
                    if (ret_q == RET_RD) begin
                        // beat_q is 0 here, so the first beat is launched on this edge
                        state_d = ST_RD_DATA;
                        valid_d = 1'b1;
                        dout_d  = mem_rd_data;
                        beat_d  = beat_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_RD_DATA: begin
                err_d = readMem | writeMem;
                if (beat_q == '0) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    dout_d = mem_rd_data;
                    beat_d = beat_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            ret_q   <= RET_NONE;
            beat_q  <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign readyMem     = ready_q;
    assign dataValidMem = valid_q;
    assign protocolErr  = err_q;
    assign dataMM       = valid_q ? dout_q : {dataWIDTH{1'bz}};

endmodule

// File: tb/tb_main_mem_responder.sv
// tb/tb_main_mem_responder.sv - directed self-checking bench for main_mem_responder
module tb_main_mem_responder;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        readMem = 1'b0;
    logic        writeMem = 1'b0;
    logic [15:0] adrMM = '0;
    wire  [7:0]  dataMM;
    logic        readyMem;
    logic        dataValidMem;
    logic        protocolErr;

    logic        tb_en = 1'b0;
    logic [7:0]  tb_data = '0;

    int total = 0;
    int bad   = 0;

    assign dataMM = tb_en ? tb_data : 8'hzz;

    always #5 CLK = ~CLK;

    main_mem_responder #(
        .MEM_DEPTH_LOG2 (10),
        .LATENCY        (LAT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .readMem      (readMem),
        .writeMem     (writeMem),
        .adrMM        (adrMM),
        .dataMM       (dataMM),
        .readyMem     (readyMem),
        .dataValidMem (dataValidMem),
        .protocolErr  (protocolErr)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [15:0] adr, input logic [31:0] d, input string nm);
        writeMem = 1'b1;
        adrMM    = adr;
        tick();
        writeMem = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                tb_en   = 1'b1;
                tb_data = d[31-8*i -: 8];
            end else begin
                tb_en = 1'b0;
            end
            total++;
            if (readyMem !== 1'b0 || dataValidMem !== 1'b0) begin
                bad++;
                $display("FAIL %s wr_busy[%0d]: ready=%b valid=%b, want ready=0 valid=0", nm, i, readyMem, dataValidMem);
            end
            tick();
        end
        total++;
        if (readyMem !== 1'b1 || dataValidMem !== 1'b0) begin
            bad++;
            $display("FAIL %s wr_done: ready=%b valid=%b, want ready=1 valid=0", nm, readyMem, dataValidMem);
        end
    endtask

    task automatic do_read(input logic [15:0] adr, input logic [31:0] exp, input string nm, input bit inject);
        readMem = 1'b1;
        adrMM   = adr;
        tick();
        readMem = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            total++;
            if (readyMem !== 1'b0 || dataValidMem !== 1'b0) begin
                bad++;
                $display("FAIL %s rd_busy[%0d]: ready=%b valid=%b, want ready=0 valid=0", nm, i, readyMem, dataValidMem);
            end
            if (inject && i == 1) readMem = 1'b1;
            if (inject && i == 2) begin
                readMem = 1'b0;
                total++;
                if (protocolErr !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy_err: protocolErr=%b, want 1", nm, protocolErr);
                end
            end
            if (inject && i == 3) begin
                total++;
                if (protocolErr !== 1'b0) begin
                    bad++;
                    $display("FAIL %s busy_err_end: protocolErr=%b, want 0", nm, protocolErr);
                end
            end
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            total++;
            if (dataValidMem !== 1'b1 || readyMem !== 1'b1 || dataMM !== exp[31-8*b -: 8]) begin
                bad++;
                $display("FAIL %s beat[%0d]: valid=%b ready=%b data=%h, want valid=1 ready=1 data=%h",
                         nm, b, dataValidMem, readyMem, dataMM, exp[31-8*b -: 8]);
            end
            tick();
        end
        total++;
        if (dataValidMem !== 1'b0 || readyMem !== 1'b1) begin
            bad++;
            $display("FAIL %s rd_done: valid=%b ready=%b, want valid=0 ready=1", nm, dataValidMem, readyMem);
        end
    endtask

    task automatic probe_bus(input string nm);
        tb_en   = 1'b1;
        tb_data = 8'hA5;
        #1;
        total++;
        if (dataMM !== 8'hA5) begin
            bad++;
            $display("FAIL %s bus_released: dataMM=%h, want A5 from bench driver", nm, dataMM);
        end
        tb_en = 1'b0;
    endtask

    task automatic test_reset;
        RST     = 1'b0;
        readMem = 1'b1;
        adrMM   = 16'h0010;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (readyMem !== 1'b1 || dataValidMem !== 1'b0 || protocolErr !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b, want 1 0 0", readyMem, dataValidMem, protocolErr);
        end
        probe_bus("reset");
        readMem = 1'b0;
        RST     = 1'b1;
        tick();
        total++;
        if (readyMem !== 1'b1 || dataValidMem !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1 0", readyMem, dataValidMem);
        end
    endtask

    task automatic test_read;
        do_write(16'h0090, 32'hAABBCCDD, "rd_setup");
        do_read(16'h0093, 32'hAABBCCDD, "read", 1'b0);
    endtask

    task automatic test_write_read;
        do_write(16'h0040, 32'h11223344, "wr");
        do_read(16'h0040, 32'h11223344, "wr_rd", 1'b0);
    endtask

    task automatic test_illegal;
        readMem  = 1'b1;
        writeMem = 1'b1;
        adrMM    = 16'h0040;
        tb_en    = 1'b1;
        tb_data  = 8'h99;
        tick();
        readMem  = 1'b0;
        writeMem = 1'b0;
        tb_en    = 1'b0;
        total++;
        if (protocolErr !== 1'b1 || readyMem !== 1'b1 || dataValidMem !== 1'b0) begin
            bad++;
            $display("FAIL both_req: err=%b ready=%b valid=%b, want 1 1 0", protocolErr, readyMem, dataValidMem);
        end
        tick();
        total++;
        if (protocolErr !== 1'b0 || readyMem !== 1'b1) begin
            bad++;
            $display("FAIL both_req_end: err=%b ready=%b, want 0 1", protocolErr, readyMem);
        end
        do_read(16'h0040, 32'h11223344, "busy_req", 1'b1);
    endtask

    task automatic test_reset_mid;
        readMem = 1'b1;
        adrMM   = 16'h0090;
        tick();
        readMem = 1'b0;
        repeat (LAT + 1) tick();
        total++;
        if (dataValidMem !== 1'b1 || dataMM !== 8'hBB) begin
            bad++;
            $display("FAIL mid_beat2: valid=%b data=%h, want 1 BB", dataValidMem, dataMM);
        end
        RST = 1'b0;
        #1;
        total++;
        if (dataValidMem !== 1'b0 || readyMem !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: valid=%b ready=%b, want 0 1", dataValidMem, readyMem);
        end
        probe_bus("mid_reset");
        @(posedge CLK);
        #1;
        RST = 1'b1;
        tick();
        do_read(16'h0090, 32'hAABBCCDD, "after_reset", 1'b0);
    endtask

    task automatic test_alias;
        do_write(16'h0400, 32'h5E6F7081, "alias_wr");
        do_read(16'h0000, 32'h5E6F7081, "alias_rd", 1'b0);
        probe_bus("alias_idle");
        do_read(16'h0402, 32'h5E6F7081, "alias_rd2", 1'b0);
    endtask

    task automatic test_back_to_back;
        do_write(16'h0124, 32'hC1C2C3C4, "b2b_wr");
        do_read(16'h0124, 32'hC1C2C3C4, "b2b_rd0", 1'b0);
        do_read(16'h0040, 32'h11223344, "b2b_rd1", 1'b0);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_illegal();
        test_reset_mid();
        test_alias();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
